// File: rtl/conv_window_gen_pkg.sv
// rtl/conv_window_gen_pkg.sv - shared defaults, state encoding and helpers for conv_window_gen
package conv_window_gen_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IMG_W  = 8;
  localparam int DEF_IMG_H  = 8;

  // Counter widths never drop below 1 bit, even for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int COL_W = clog2_min1(DEF_IMG_W);
  localparam int ROW_W = clog2_min1(DEF_IMG_H);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/conv_window_gen_if.sv
// rtl/conv_window_gen_if.sv - pixel stream in, window/handshake out to the conv engine
interface conv_window_gen_if #(
  parameter int DATA_W = conv_window_gen_pkg::DEF_DATA_W,
  parameter int ROW_W  = conv_window_gen_pkg::ROW_W,
  parameter int COL_W  = conv_window_gen_pkg::COL_W
);
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic [DATA_W-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic              conv_start;
  logic              conv_done;
  logic [ROW_W-1:0]  out_row;
  logic [COL_W-1:0]  out_col;
  logic              frame_done;

  modport master (
    input  pix_valid, pix_data, conv_done,
    output pix_ready, win0, win1, win2, win3, win4, win5, win6, win7, win8,
    output conv_start, out_row, out_col, frame_done
  );

  modport slave (
    output pix_valid, pix_data, conv_done,
    input  pix_ready, win0, win1, win2, win3, win4, win5, win6, win7, win8,
    input  conv_start, out_row, out_col, frame_done
  );
endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// rtl/conv_window_gen_line_buffer.sv - one image row of storage, read-before-write at one address
module conv_window_gen_line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  // Contents are deliberately unreset; rows 0-1 of a frame never issue a window.
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - builds 3x3 windows from a raster stream and hands them to the conv engine
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  conv_window_gen_if.master bus
);

  localparam int CW = clog2_min1(IMG_W);
  localparam int RW = clog2_min1(IMG_H);

  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
  localparam logic [CW-1:0] OUT_COL_LAST = CW'(IMG_W - 3);
  localparam logic [RW-1:0] OUT_ROW_LAST = RW'(IMG_H - 3);

  state_t                  state_q, state_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [8:0][DATA_W-1:0]  win_q, win_d;
  logic [RW-1:0]           out_row_q, out_row_d;
  logic [CW-1:0]           out_col_q, out_col_d;
  logic                    pix_ready_q, pix_ready_d;
  logic                    conv_start_q, conv_start_d;
  logic                    frame_done_q, frame_done_d;

  logic                    xfer;
  logic [DATA_W-1:0]       lb0_rd;
  logic [DATA_W-1:0]       lb1_rd;

  assign xfer = bus.pix_valid && pix_ready_q && (state_q == FILL);

  // lb0 holds row r-1, lb1 holds row r-2; each accepted pixel pushes a column up.
  conv_window_gen_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(CW)) u_lb0 (
    .clk     (clk),
    .wr_en   (xfer),
    .addr    (col_q),
    .wr_data (bus.pix_data),
    .rd_data (lb0_rd)
  );

  conv_window_gen_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(CW)) u_lb1 (
    .clk     (clk),
    .wr_en   (xfer),
    .addr    (col_q),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      FILL: begin
        if (xfer) begin
          for (int k = 0; k < 3; k++) begin
            win_d[3*k]   = win_q[3*k+1];
            win_d[3*k+1] = win_q[3*k+2];
          end
          win_d[2] = lb1_rd;
          win_d[5] = lb0_rd;
          win_d[8] = bus.pix_data;

          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end

          // Only windows fully inside the current frame rows/cols are issued.
          if (row_q >= RW'(2) && col_q >= CW'(2)) begin
            state_d   = ISSUE;
            out_row_d = row_q - RW'(2);
            out_col_d = col_q - CW'(2);
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.conv_done) begin
          state_d      = FILL;
          frame_done_d = (out_row_q == OUT_ROW_LAST) && (out_col_q == OUT_COL_LAST);
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    // Registered so both strobes are clean and reset to 0 while state is FILL.
    pix_ready_d  = (state_d == FILL);
    conv_start_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      pix_ready_q  <= 1'b0;
      conv_start_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      pix_ready_q  <= pix_ready_d;
      conv_start_q <= conv_start_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.pix_ready  = pix_ready_q;
  assign bus.conv_start = conv_start_q;
  assign bus.frame_done = frame_done_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
  assign bus.win0       = win_q[0];
  assign bus.win1       = win_q[1];
  assign bus.win2       = win_q[2];
  assign bus.win3       = win_q[3];
  assign bus.win4       = win_q[4];
  assign bus.win5       = win_q[5];
  assign bus.win6       = win_q[6];
  assign bus.win7       = win_q[7];
  assign bus.win8       = win_q[8];

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - directed bench for conv_window_gen with an engine responder
module tb_conv_window_gen;
  import conv_window_gen_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_window_gen_if #(.DATA_W(DEF_DATA_W), .ROW_W(ROW_W), .COL_W(COL_W)) bus_if ();

  conv_window_gen #(.IMG_W(DEF_IMG_W), .IMG_H(DEF_IMG_H), .DATA_W(DEF_DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    int          ord;
    int          r;
    int          c;
    logic [71:0] w;
  } vec_t;

  int total = 0;
  int bad   = 0;

  bit active    = 0;
  int done_dly  = 4;
  int pix_idx   = 0;
  int iss       = 0;
  int fd_cnt    = 0;
  int cnt       = 0;
  bit busy      = 0;
  bit done_prev = 0;
  bit prev_xfer = 0;
  int exp_r     = 0;
  int exp_c     = 0;

  logic [71:0] cap_w [144];
  int          cap_r [144];
  int          cap_c [144];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame f carries a ramp offset by 53*f so frame data is distinguishable.
  function automatic logic [7:0] pixval(input int g);
    int f;
    int p;
    f = g / 64;
    p = g % 64;
    return 8'((p + f * 53) & 255);
  endfunction

  function automatic logic [71:0] exp_win(input int n_glob);
    int f, n, r, c;
    logic [71:0] w;
    f = n_glob / 36;
    n = n_glob % 36;
    r = n / 6;
    c = n % 6;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      w = {w[63:0], pixval(f * 64 + (r + k / 3) * 8 + c + k % 3)};
    end
    return w;
  endfunction

  function automatic logic [71:0] dut_win();
    return {bus_if.win0, bus_if.win1, bus_if.win2, bus_if.win3, bus_if.win4,
            bus_if.win5, bus_if.win6, bus_if.win7, bus_if.win8};
  endfunction

  // Stream driver, engine responder and per-cycle checker, all on the falling edge.
  initial begin
    bus_if.pix_valid = 1'b0;
    bus_if.pix_data  = '0;
    bus_if.conv_done = 1'b0;
    forever begin
      @(negedge clk);
      bus_if.conv_done = 1'b0;
      if (!active) begin
        bus_if.pix_valid = 1'b0;
      end else begin
        if (prev_xfer) pix_idx++;
        if (bus_if.frame_done) fd_cnt++;
        if (done_prev) begin
          chk("ready_after_done", bus_if.pix_ready, 1'b1);
          chk("frame_done_pulse", bus_if.frame_done, (exp_r == 5 && exp_c == 5));
          busy      = 0;
          done_prev = 0;
        end else begin
          chk("frame_done_idle", bus_if.frame_done, 1'b0);
        end

        if (bus_if.conv_start) begin
          exp_r = (iss % 36) / 6;
          exp_c = (iss % 36) % 6;
          chk("start_in_wait", busy, 1'b0);
          chk("ready_in_issue", bus_if.pix_ready, 1'b0);
          chk("win_at_start", dut_win(), exp_win(iss));
          chk("out_row", bus_if.out_row, exp_r);
          chk("out_col", bus_if.out_col, exp_c);
          chk("trigger_index", pix_idx, (iss / 36) * 64 + (exp_r + 2) * 8 + exp_c + 3);
          if (iss < 144) begin
            cap_w[iss] = dut_win();
            cap_r[iss] = int'(bus_if.out_row);
            cap_c[iss] = int'(bus_if.out_col);
          end
          busy = 1;
          cnt  = done_dly;
          iss++;
        end else if (busy) begin
          chk("ready_in_wait", bus_if.pix_ready, 1'b0);
          chk("win_hold", dut_win(), exp_win(iss - 1));
          chk("coord_hold", {bus_if.out_row, bus_if.out_col}, {3'(exp_r), 3'(exp_c)});
          cnt--;
          if (cnt == 0) begin
            bus_if.conv_done = 1'b1;
            done_prev = 1;
          end
        end else begin
          chk("ready_in_fill", bus_if.pix_ready, 1'b1);
          if (pix_idx % 7 == 3) bus_if.conv_done = 1'b1;
        end

        bus_if.pix_valid = 1'b1;
        bus_if.pix_data  = pixval(pix_idx);
        prev_xfer = bus_if.pix_ready;
      end
    end
  end

  initial begin
    vec_t vecs [7];
    vecs[0] = '{0,  0, 0, 72'h00_01_02_08_09_0a_10_11_12};
    vecs[1] = '{1,  0, 1, 72'h01_02_03_09_0a_0b_11_12_13};
    vecs[2] = '{15, 2, 3, 72'h13_14_15_1b_1c_1d_23_24_25};
    vecs[3] = '{18, 3, 0, 72'h18_19_1a_20_21_22_28_29_2a};
    vecs[4] = '{35, 5, 5, 72'h2d_2e_2f_35_36_37_3d_3e_3f};
    vecs[5] = '{36, 0, 0, 72'h35_36_37_3d_3e_3f_45_46_47};
    vecs[6] = '{71, 5, 5, 72'h62_63_64_6a_6b_6c_72_73_74};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pix_ready", bus_if.pix_ready, 1'b0);
    chk("rst_conv_start", bus_if.conv_start, 1'b0);
    chk("rst_frame_done", bus_if.frame_done, 1'b0);
    chk("rst_win", dut_win(), 72'h0);
    chk("rst_out_row", bus_if.out_row, 3'd0);
    chk("rst_out_col", bus_if.out_col, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 active = 1;

    // Frame A: nominal 4-cycle engine with spurious dones while filling.
    for (int t = 0; t < 4000 && fd_cnt < 1; t++) @(negedge clk);
    chk("frame_a_done_seen", fd_cnt >= 1, 1'b1);
    chk("frame_a_starts", iss, 36);

    // Frame B follows with no gap; engine now takes 20 cycles per window.
    done_dly = 20;
    for (int t = 0; t < 8000 && fd_cnt < 2; t++) @(negedge clk);
    chk("frame_b_done_seen", fd_cnt >= 2, 1'b1);
    chk("frame_b_starts", iss, 72);
    done_dly = 4;

    for (int i = 0; i < 7; i++) begin
      chk("tbl_win", cap_w[vecs[i].ord], vecs[i].w);
      chk("tbl_row", cap_r[vecs[i].ord], vecs[i].r);
      chk("tbl_col", cap_c[vecs[i].ord], vecs[i].c);
    end

    // Frame C: reset while the engine holds window (2,3).
    for (int t = 0; t < 2000 && iss < 88; t++) @(negedge clk);
    chk("frame_c_reach_2_3", iss, 88);
    repeat (2) @(negedge clk);
    chk("in_wait_before_rst", busy, 1'b1);
    #2;
    rst_n  = 1'b0;
    active = 0;
    #1;
    chk("arst_pix_ready", bus_if.pix_ready, 1'b0);
    chk("arst_conv_start", bus_if.conv_start, 1'b0);
    chk("arst_frame_done", bus_if.frame_done, 1'b0);
    chk("arst_win", dut_win(), 72'h0);
    chk("arst_out", {bus_if.out_row, bus_if.out_col}, 6'd0);
    pix_idx   = 0;
    iss       = 0;
    fd_cnt    = 0;
    cnt       = 0;
    busy      = 0;
    done_prev = 0;
    prev_xfer = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 active = 1;

    // Frame D: restart from row 0 col 0 after the reset.
    for (int t = 0; t < 4000 && fd_cnt < 1; t++) @(negedge clk);
    chk("frame_d_done_seen", fd_cnt, 1);
    chk("frame_d_starts", iss, 36);
    repeat (20) @(negedge clk);
    chk("frame_d_single_done", fd_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Producer and initiator for the 3x3 convolution engine: takes a raster-order pixel stream and builds 3x3 sliding windows using two line buffers.
- Presents each valid window on the conv engine's in0..in8 inputs and pulses start.
- Holds the window stable until the engine's done, then resumes the stream.
- Sits between the input DMA/stream interface and the conv datapath.
- Emits the window's output coordinates so the result writer can place the engine's output.

Parameters:
- IMG_W, 8, image width in pixels (>=3).
- IMG_H, 8, image height in pixels (>=3).
- DATA_W, 8, pixel width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pix_valid  input  1  stream pixel valid.
- pix_data  input  DATA_W  stream pixel, raster order, row 0 col 0 first.
- pix_ready  output  1  block accepts pixel this cycle; a transfer occurs when pix_valid and pix_ready are both high.
- win0..win8  output  DATA_W each  window; win0..2 = row r-2, win3..5 = row r-1, win6..8 = row r; within a row, cols c-2, c-1, c.
- conv_start  output  1  one-cycle pulse, window valid and stable.
- conv_done  input  1  engine completion pulse.
- out_row  output  clog2(IMG_H)  output row of the issued window = r-2.
- out_col  output  clog2(IMG_W)  output col of the issued window = c-2.
- frame_done  output  1  one-cycle pulse after the last window's conv_done.

Behaviour:
- Reset values:
  - pix_ready=0, conv_start=0, frame_done=0.
  - win0..8=0, out_row=0, out_col=0.
  - col/row counters=0, state=FILL.
  - Line buffer contents are not reset.
- State FILL:
  - pix_ready=1.
  - On each transfer at (row,col):
    - window shifts one column left;
    - new right column = {lb1[col], lb0[col], pix_data};
    - lb1[col] <= lb0[col], lb0[col] <= pix_data;
    - col increments, wrapping to 0 at IMG_W-1 with row++;
    - row wraps to 0 at IMG_H-1.
  - If the transferred pixel has row>=2 and col>=2, go to ISSUE and latch out_row=row-2, out_col=col-2. Otherwise stay in FILL.
- State ISSUE:
  - pix_ready=0, conv_start=1 for exactly this one cycle.
  - Next state is WAIT.
- State WAIT:
  - pix_ready=0, conv_start=0.
  - win0..8, out_row and out_col are held constant, because the engine samples its inputs live for 3 cycles.
  - On conv_done, return to FILL.
  - If that window was at the last frame position (out_row=IMG_H-3, out_col=IMG_W-3), also pulse frame_done for 1 cycle in the same cycle FILL is re-entered.
- No timeout; WAIT lasts indefinitely until conv_done.
- Nominal timing: the engine returns done 4 cycles after conv_start, so each window costs 6 cycles including the triggering pixel.
- conv_done outside WAIT is ignored.
- pix_valid while pix_ready=0 is not consumed; the upstream holds the pixel.
- Wrap-around:
  - Windows that straddle a row boundary (col<2) are never issued.
  - Rows 0-1 of a new frame never issue, so stale line-buffer data is harmless.
  - Frame N+1 pixels may be accepted immediately after the last conv_done.
- Windows per frame = (IMG_W-2)*(IMG_H-2).
- Reset asserted mid-operation:
  - all outputs and counters return to reset values asynchronously;
  - any in-flight engine result is discarded;
  - streaming restarts at row 0 col 0.
- No arithmetic on pixel data; counters are unsigned and compared only for equality and >=.

Decomposition:
- Shared package: DATA_W default; state encoding (FILL, ISSUE, WAIT); localparam COL_W=clog2(IMG_W), ROW_W=clog2(IMG_H).
- One sub-module: line_buffer (depth IMG_W, width DATA_W, one write and one read at the same address, registered or combinational read). Instantiate it twice, chained lb0 -> lb1.
- Window registers and the FSM stay in the top module.

Test Plan:
- Ramp frame with pix=(row*8+col)&0xFF, IMG_W=IMG_H=8, conv_done returned 4 cycles after conv_start -> first conv_start follows pixel index 18 with win0..8=0,1,2,8,9,10,16,17,18 and out_row=0, out_col=0. Last window has win0..8=45,46,47,53,54,55,61,62,63 and out_row=5, out_col=5.
- Full-frame count -> exactly 36 conv_start pulses, 1 frame_done, pix_ready never high in ISSUE/WAIT, and window stable throughout every WAIT.
- conv_done delayed 20 cycles, with pix_valid held high -> pix_ready stays 0 and win0..8 stay unchanged for 20 cycles; the next pixel is accepted the cycle after done.
- Spurious conv_done pulses during FILL -> no state change and no extra conv_start.
- rst_n low during WAIT at window (2,3), then a new frame -> outputs reset immediately; the first conv_start again comes after pixel 18 with correct values.
- Back-to-back frames without gaps -> frame 2 windows are correct; no window is issued for frame-2 rows 0-1.
